// File: rtl/jstk_pkg.sv
// Shared types and constants for the dual-joystick poll scheduler.
// Optional build macro: JSTK_FRAME_CHECK_EN (reserved-bit frame check).
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_FINISH,
    ST_NEXT
  } jstk_state_t;

  localparam int JSTK_FRAME_BYTES = 5;
  localparam logic [5:0] JSTK_CMD_PREFIX = 6'b100000;

  // Byte positions of the fields inside the 5-byte reply frame
  localparam int JSTK_IDX_X_LO = 0;
  localparam int JSTK_IDX_X_HI = 1;
  localparam int JSTK_IDX_Y_LO = 2;
  localparam int JSTK_IDX_Y_HI = 3;
  localparam int JSTK_IDX_BTN  = 4;

  // A reply is well formed when every bit outside the X/Y/button fields is zero
  function automatic logic jstk_frame_ok(input logic [7:0] x_hi,
                                         input logic [7:0] y_hi,
                                         input logic [7:0] btn);
    return (x_hi[7:2] == 6'd0) && (y_hi[7:2] == 6'd0) && (btn[7:3] == 5'd0);
  endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// SPI mode-0 single-byte engine: SCLK idles low, MOSI changes on the falling
// edge, MISO is sampled on the rising edge. Bit 7 drives MOSI from the cycle
// after start. done is a one-cycle pulse in the cycle whose clock edge makes
// the final SCLK falling edge, so a caller reacting to it loses no cycle.
module spi_byte_engine #(
  parameter int SCLK_HALF = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       done
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [HW-1:0] HLAST = HW'(SCLK_HALF - 1);

  logic          active;
  logic [HW-1:0] half_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic          sclk_reg;

  assign sclk    = sclk_reg;
  assign mosi    = tx_sh[7];
  assign rx_byte = rx_sh;
  assign done    = active && (half_cnt == HLAST) && sclk_reg && (bit_cnt == 3'd7);

  // SCLK divider plus transmit/receive shift registers for one byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active   <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= 3'd0;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      sclk_reg <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      half_cnt <= '0;
      bit_cnt  <= 3'd0;
      tx_sh    <= tx_byte;
      sclk_reg <= 1'b0;
    end else if (active) begin
      if (half_cnt == HLAST) begin
        half_cnt <= '0;
        sclk_reg <= ~sclk_reg;
        if (!sclk_reg) begin
          rx_sh <= {rx_sh[6:0], miso};
        end else begin
          // zero fill leaves MOSI low once the byte is out
          tx_sh   <= {tx_sh[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) active <= 1'b0;
        end
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jstk_poll_scheduler.sv
// Polls two PmodJSTK-style joysticks through one shared SPI byte engine:
// device 0 then device 1 each round, 5-byte frames, results latched per device.
// Optional build macro: JSTK_FRAME_CHECK_EN adds reserved-bit frame rejection
// and the sticky frame_err_0/frame_err_1 outputs.
// SS_SETUP and BYTE_GAP are measured up to the next SCLK rising edge, so the
// SETUP/GAP waits are shortened by the engine's leading low half-period.
module jstk_poll_scheduler
  import jstk_pkg::*;
#(
  parameter int SCLK_HALF   = 50,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] led_0,
  input  logic [1:0] led_1,
  input  logic       MISO_1,
  input  logic       MISO_2,
  output logic       SS_1,
  output logic       SS_2,
  output logic       MOSI,
  output logic       SCLK,
  output logic [9:0] x_0,
  output logic [9:0] y_0,
  output logic [2:0] btn_0,
  output logic       upd_0,
  output logic [9:0] x_1,
  output logic [9:0] y_1,
  output logic [2:0] btn_1,
  output logic       upd_1,
  output logic       busy
`ifdef JSTK_FRAME_CHECK_EN
  ,
  output logic       frame_err_0,
  output logic       frame_err_1
`endif
);

  localparam int CW = $clog2(POLL_PERIOD);
  localparam logic [CW-1:0] PLAST = CW'(POLL_PERIOD - 1);
  localparam int TMAX = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SETUP_LOAD = TW'(SS_SETUP - SCLK_HALF - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(BYTE_GAP - SCLK_HALF - 1);
  localparam logic [2:0] LAST_IDX = 3'(JSTK_FRAME_BYTES - 1);

  jstk_state_t   state;
  logic [CW-1:0] period_cnt;
  logic [TW-1:0] tmr;
  logic [2:0]    byte_idx;
  logic          dev;
  logic [1:0]    led_lat;
  logic [7:0]    stage [JSTK_FRAME_BYTES];

  logic       round_start;
  logic       eng_start;
  logic [7:0] eng_tx;
  logic       eng_miso;
  logic [7:0] eng_rx;
  logic       eng_done;
  logic       frame_good;
  logic [9:0] new_x;
  logic [9:0] new_y;
  logic [2:0] new_btn;

  assign round_start = (state == ST_IDLE) && enable && (period_cnt == PLAST);
  assign eng_start   = ((state == ST_SETUP) || (state == ST_GAP)) && (tmr == '0);
  assign eng_tx      = (state == ST_SETUP) ? {JSTK_CMD_PREFIX, led_lat} : 8'h00;
  assign eng_miso    = dev ? MISO_2 : MISO_1;

  // The button byte is still in the engine when the frame completes
  assign new_x   = {stage[JSTK_IDX_X_HI][1:0], stage[JSTK_IDX_X_LO]};
  assign new_y   = {stage[JSTK_IDX_Y_HI][1:0], stage[JSTK_IDX_Y_LO]};
  assign new_btn = eng_rx[2:0];
`ifdef JSTK_FRAME_CHECK_EN
  assign frame_good = jstk_frame_ok(stage[JSTK_IDX_X_HI], stage[JSTK_IDX_Y_HI], eng_rx);
`else
  assign frame_good = 1'b1;
`endif

  spi_byte_engine #(.SCLK_HALF(SCLK_HALF)) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (eng_start),
    .tx_byte (eng_tx),
    .miso    (eng_miso),
    .sclk    (SCLK),
    .mosi    (MOSI),
    .rx_byte (eng_rx),
    .done    (eng_done)
  );

  // Poll period timer: reloads at each round start, then saturates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     period_cnt <= '0;
    else if (round_start)         period_cnt <= '0;
    else if (period_cnt != PLAST) period_cnt <= period_cnt + 1'b1;
  end

  // Round sequencer: selects, frames and commits each device in turn
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tmr      <= '0;
      byte_idx <= 3'd0;
      dev      <= 1'b0;
      led_lat  <= 2'b00;
      SS_1     <= 1'b1;
      SS_2     <= 1'b1;
      busy     <= 1'b0;
      x_0      <= '0;
      y_0      <= '0;
      btn_0    <= '0;
      upd_0    <= 1'b0;
      x_1      <= '0;
      y_1      <= '0;
      btn_1    <= '0;
      upd_1    <= 1'b0;
      for (int i = 0; i < JSTK_FRAME_BYTES; i++) stage[i] <= 8'h00;
`ifdef JSTK_FRAME_CHECK_EN
      frame_err_0 <= 1'b0;
      frame_err_1 <= 1'b0;
`endif
    end else begin
      upd_0 <= 1'b0;
      upd_1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (round_start) begin
            state   <= ST_SETUP;
            dev     <= 1'b0;
            SS_1    <= 1'b0;
            busy    <= 1'b1;
            led_lat <= led_0;
            tmr     <= SETUP_LOAD;
          end
        end
        ST_SETUP: begin
          if (tmr == '0) begin
            state    <= ST_SHIFT;
            byte_idx <= 3'd0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (eng_done) begin
            stage[byte_idx] <= eng_rx;
            if (byte_idx < LAST_IDX) begin
              state <= ST_GAP;
              tmr   <= GAP_LOAD;
            end else begin
              // Entering FINISH: deselect and commit so both show in that cycle
              state <= ST_FINISH;
              if (dev) SS_2 <= 1'b1;
              else     SS_1 <= 1'b1;
              if (frame_good) begin
                if (dev) begin
                  x_1   <= new_x;
                  y_1   <= new_y;
                  btn_1 <= new_btn;
                  upd_1 <= 1'b1;
                end else begin
                  x_0   <= new_x;
                  y_0   <= new_y;
                  btn_0 <= new_btn;
                  upd_0 <= 1'b1;
                end
              end
`ifdef JSTK_FRAME_CHECK_EN
              if (!frame_good) begin
                if (dev) frame_err_1 <= 1'b1;
                else     frame_err_0 <= 1'b1;
              end
`endif
            end
          end
        end
        ST_GAP: begin
          if (tmr == '0) begin
            state    <= ST_SHIFT;
            byte_idx <= byte_idx + 3'd1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_FINISH: begin
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (!dev) begin
            state   <= ST_SETUP;
            dev     <= 1'b1;
            SS_2    <= 1'b0;
            led_lat <= led_1;
            tmr     <= SETUP_LOAD;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/jstk_poll_scheduler.md
Name: jstk_poll_scheduler

Overview:
- Sequences one shared SPI mode-0 byte engine across the two joystick modules (PmodJSTK-style, 5-byte frames).
- Polls device 0 then device 1 once per poll round; asserts the matching SS; demultiplexes MISO.
- Latches X/Y/button results per device and pulses an update strobe.
- Sits between the joystick Pmod pins and the direction decoders/senders. Top level fans SCLK/MOSI out to both connectors.

Parameters:
- SCLK_HALF, 50: clk cycles per SCLK half-period; 1 MHz at 100 MHz clk.
- SS_SETUP, 1500: clk cycles from SS falling to the first SCLK rising edge (15 us).
- BYTE_GAP, 1000: idle clk cycles between bytes, with SS held low (10 us).
- POLL_PERIOD, 1000000: clk cycles between successive round starts (10 ms).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  start new rounds while high.
- led_0  in  2  LED command for device 0.
- led_1  in  2  LED command for device 1.
- MISO_1  in  1  serial data from device 0.
- MISO_2  in  1  serial data from device 1.
- SS_1  out  1  active-low select, device 0.
- SS_2  out  1  active-low select, device 1.
- MOSI  out  1  shared serial data out.
- SCLK  out  1  shared serial clock.
- x_0, y_0  out  10  device 0 position.
- btn_0  out  3  device 0 buttons.
- upd_0  out  1  one-cycle strobe: device 0 results updated.
- x_1, y_1, btn_1, upd_1: same four outputs for device 1.
- busy  out  1  high while a round is in progress.

Behaviour:
- Reset (rst low, asynchronous): SS_1=SS_2=1, SCLK=0, MOSI=0, all x/y/btn=0, upd=0, busy=0, FSM=IDLE, period counter=0.
- The period counter runs freely after reset. It reloads at each round start and saturates at POLL_PERIOD-1.
- FSM states: IDLE, SETUP, SHIFT, GAP, FINISH, NEXT.
- IDLE -> SETUP when enable=1 and the period counter has expired. Selects device 0, drops its SS, sets busy=1.
- If a round overruns POLL_PERIOD, the next round starts on the first IDLE cycle.
- SETUP: wait SS_SETUP cycles, then -> SHIFT with byte index=0.
- SHIFT: the engine transfers 8 bits, MSB first, in 16*SCLK_HALF cycles.
  - SCLK idles low; MOSI changes on the falling edge. Bit 7 is valid at SHIFT entry.
  - MISO of the selected device is sampled on the rising edge.
  - On completion, if index<4 -> GAP; else -> FINISH.
- GAP: wait BYTE_GAP cycles, increment index, -> SHIFT.
- TX bytes: byte0 = {6'b100000, led_n} (led_n sampled at SETUP entry); bytes 1-4 = 8'h00.
- RX mapping:
  - x[7:0] = rx0, x[9:8] = rx1[1:0].
  - y[7:0] = rx2, y[9:8] = rx3[1:0].
  - btn = rx4[2:0].
- Results are shifted into a staging register and committed only in FINISH.
- FINISH (1 cycle): SS of the current device goes high, staged results are committed to that device's outputs, and upd_n pulses high for this single cycle. Then -> NEXT.
- NEXT: if the current device is 0, select device 1, drop SS_2, -> SETUP. Otherwise busy=0 -> IDLE.
- The two SS lines are never low simultaneously. The deselected device's outputs hold their values.
- enable deasserted mid-round: the round completes, both devices are polled, and no new round starts.
- led_n changing mid-frame has no effect until that device's next SETUP.
- Reset mid-frame aborts with no commit and no upd pulse.

Optional Feature:
- JSTK_FRAME_CHECK_EN defined:
  - In FINISH, the frame is rejected if rx1[7:2], rx3[7:2] or rx4[7:3] is nonzero.
  - On rejection there is no commit and no upd pulse; sticky output frame_err_n (1 bit per device) is set.
  - frame_err_n is cleared only by reset.
- Undefined: no check; rx bits outside the mapping are ignored; frame_err ports are absent.

Decomposition:
- Package jstk_pkg holds:
  - FSM state enum.
  - JSTK_FRAME_BYTES=5.
  - JSTK_CMD_PREFIX=6'b100000.
  - Byte-index constants for the X/Y/BTN fields.
- One sub-module: spi_byte_engine, mode 0, SCLK_HALF parameter.
  - Interface: start, tx_byte[7:0], miso, sclk, mosi, rx_byte[7:0], done pulse.
  - Owns the SCLK divider and shift register. The scheduler owns SS, timing and demux.

Test Plan:
- Reset, then enable=1 with small parameters (SCLK_HALF=2, SS_SETUP=10, BYTE_GAP=8, POLL_PERIOD=2000); device model 0 returns 8'hA5,8'h02,8'h3C,8'h01,8'h05 -> x_0=10'h2A5, y_0=10'h13C, btn_0=3'b101, upd_0 one cycle exactly when SS_1 rises.
- Device 1 model with led_1=2'b11 -> MOSI first byte 8'h83, then four 8'h00. SS_2 falls only after SS_1 high. upd_1 follows upd_0.
- Timing check with the same small parameters:
  - First SCLK rise exactly SS_SETUP cycles after SS fall.
  - Gap between bytes is BYTE_GAP cycles.
  - Round starts are spaced 2000 cycles apart.
- Drop enable in the middle of the device 0 frame -> device 1 is still polled, busy falls, and no further SS activity occurs.
- Assert rst during SHIFT of byte 2 -> SS_1 goes high immediately, all outputs are 0, and no upd pulse occurs.
- With JSTK_FRAME_CHECK_EN, device returns rx1=8'hFF -> no upd_0, x_0 unchanged, frame_err_0=1 until reset.
